// File: rtl/dbus_pkg.sv
// ============================================================================
// dbus_pkg : shared size and FSM encodings for the data-bus target. Rev 1.0
// ============================================================================
`default_nettype none

package dbus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic r;
    r = 1'b0;
    case (size)
      SZ_HALF: r = lo[0];
      SZ_WORD: r = (lo != 2'b00);
      SZ_ILL:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dbus_lane_align.sv
// ============================================================================
// dbus_lane_align : little-endian load extract/extend, store byte-merge. Rev 1.0
// ============================================================================
`default_nettype none

module dbus_lane_align
  import dbus_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_mem_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_wrep;

  always_comb begin
    w_byte = i_mem_word[{i_lane, 3'b000} +: 8];
    w_half = i_lane[1] ? i_mem_word[31:16] : i_mem_word[15:0];
    case (i_size)
      SZ_BYTE: o_load_data = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: o_load_data = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: o_load_data = i_mem_word;
    endcase
  end

  // Store data is replicated across lanes so the byte-enables alone select it.
  always_comb begin
    case (i_size)
      SZ_BYTE: begin
        o_be   = 4'b0001 << i_lane;
        w_wrep = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_be   = i_lane[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{i_wdata[15:0]}};
      end
      SZ_WORD: begin
        o_be   = 4'b1111;
        w_wrep = i_wdata;
      end
      default: begin
        o_be   = 4'b0000;
        w_wrep = i_wdata;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      o_merged[i*8 +: 8] = o_be[i] ? w_wrep[i*8 +: 8] : i_mem_word[i*8 +: 8];
    end
  end

endmodule

`default_nettype wire

// File: rtl/dbus_target.sv
// ============================================================================
// dbus_target : word-array data-bus target with configurable wait states. Rev 1.0
// ============================================================================
`default_nettype none

module dbus_target
  import dbus_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_idle;
  logic          w_accept;
  logic          w_enter_resp;
  logic          w_cur_we;
  logic [1:0]    w_cur_size;
  logic          w_cur_uns;
  logic [31:0]   w_cur_addr;
  logic [31:0]   w_cur_wdata;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_mem_word;
  logic [31:0]   w_load;
  logic [3:0]    w_be;
  logic [31:0]   w_merged;
  logic          w_commit;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = req_valid & w_idle;

  // With zero wait states the access completes on the accept edge itself,
  // so the live request must be used before it has been captured.
  assign w_cur_we    = w_idle ? req_we       : r_we;
  assign w_cur_size  = w_idle ? req_size     : r_size;
  assign w_cur_uns   = w_idle ? req_unsigned : r_uns;
  assign w_cur_addr  = w_idle ? req_addr     : r_addr;
  assign w_cur_wdata = w_idle ? req_wdata    : r_wdata;

  assign w_enter_resp = (WAIT_CYCLES == 0) ? w_accept
                                           : ((r_state == ST_WAIT) && (r_cnt == '0));

  assign w_err = misaligned(w_cur_size, w_cur_addr[1:0]) |
                 ({2'b00, w_cur_addr[31:2]} >= 32'(DEPTH_WORDS));

  assign w_idx      = w_cur_addr[AW+1:2];
  assign w_mem_word = r_mem[w_idx];
  assign w_commit   = w_enter_resp & w_cur_we & ~w_err;

  dbus_lane_align u_lane (
    .i_size      (w_cur_size),
    .i_unsigned  (w_cur_uns),
    .i_lane      (w_cur_addr[1:0]),
    .i_mem_word  (w_mem_word),
    .i_wdata     (w_cur_wdata),
    .o_load_data (w_load),
    .o_be        (w_be),
    .o_merged    (w_merged)
  );

  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_size  <= SZ_BYTE;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_enter_resp) begin
        r_rdata <= (w_err | w_cur_we) ? 32'd0 : w_load;
        r_err   <= w_err;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            r_cnt   <= CNT_INIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Byte-enables are folded into w_merged; kept visible for debug only.
  logic w_be_unused;
  assign w_be_unused = ^w_be;

  assign req_ready = w_idle;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dbus_target.sv
// ============================================================================
// tb_dbus_target : random + directed check of dbus_target against a byte model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_dbus_target;

  // Instance 0: WAIT_CYCLES=0, DEPTH_WORDS=16; instance 1: WAIT_CYCLES=1, DEPTH_WORDS=256
  int depth_of [2] = '{16, 256};
  int wait_of  [2] = '{0, 1};

  logic clk = 1'b0;
  logic reset;
  logic [1:0]       req_valid, req_we, req_unsigned, rsp_ready;
  logic [1:0][1:0]  req_size;
  logic [1:0][31:0] req_addr, req_wdata;
  wire  [1:0]       req_ready, rsp_valid, rsp_err;
  wire  [1:0][31:0] rsp_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] mb [2][1024];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    dbus_target #(
      .DEPTH_WORDS ((gi == 0) ? 16 : 256),
      .WAIT_CYCLES ((gi == 0) ? 0 : 1)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid[gi]),
      .req_ready    (req_ready[gi]),
      .req_we       (req_we[gi]),
      .req_size     (req_size[gi]),
      .req_unsigned (req_unsigned[gi]),
      .req_addr     (req_addr[gi]),
      .req_wdata    (req_wdata[gi]),
      .rsp_valid    (rsp_valid[gi]),
      .rsp_ready    (rsp_ready[gi]),
      .rsp_rdata    (rsp_rdata[gi]),
      .rsp_err      (rsp_err[gi])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic mdl_err(input int d, input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] dep;
    int nb;
    dep = 32'(depth_of[d]);
    if (sz == 2'd3) return 1'b1;
    nb = 1 << sz;
    if ((a % nb) != 0) return 1'b1;
    if ((a >> 2) >= dep) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mdl_load(input int d, input logic [1:0] sz, input logic un,
                                           input logic [31:0] a);
    int nb;
    int sh;
    logic [31:0] v;
    logic signed [31:0] t;
    nb = 1 << sz;
    v  = 32'd0;
    for (int i = 0; i < nb; i++) v = v | (32'(mb[d][int'(a) + i]) << (8 * i));
    if (!un && nb < 4) begin
      sh = 32 - 8 * nb;
      t  = v << sh;
      v  = t >>> sh;
    end
    return v;
  endfunction

  task automatic mdl_store(input int d, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd);
    int nb;
    nb = 1 << sz;
    for (int i = 0; i < nb; i++) mb[d][int'(a) + i] = wd[8*i +: 8];
  endtask

  task automatic txn(input int d, input logic we, input logic [1:0] sz, input logic un,
                     input logic [31:0] a, input logic [31:0] wd, input int bp,
                     input string tag, output logic [31:0] got);
    logic [31:0] exp_rd;
    logic        exp_err;
    int n;
    exp_err = mdl_err(d, sz, a);
    exp_rd  = (exp_err || we) ? 32'd0 : mdl_load(d, sz, un, a);
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = sz;
    req_unsigned[d] = un; req_addr[d] = a; req_wdata[d] = wd;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, " ready"}, 32'(req_ready[d]), 32'd1);
    @(posedge clk); #1;
    // Scramble the request bus after accept; the target must have captured it.
    req_valid[d] = 1'b0; req_we[d] = 1'($urandom); req_size[d] = 2'($urandom);
    req_unsigned[d] = 1'($urandom); req_addr[d] = $urandom; req_wdata[d] = $urandom;
    n = 1;
    while (rsp_valid[d] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, " latency"}, 32'(n), 32'(wait_of[d] + 1));
    check({tag, " rdata"}, rsp_rdata[d], exp_rd);
    check({tag, " err"}, 32'(rsp_err[d]), 32'(exp_err));
    got = rsp_rdata[d];
    if (we && !exp_err) mdl_store(d, sz, a, wd);
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      check({tag, " hold valid"}, 32'(rsp_valid[d]), 32'd1);
      check({tag, " hold rdata"}, rsp_rdata[d], exp_rd);
      check({tag, " hold ready"}, 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    check({tag, " done valid"}, 32'(rsp_valid[d]), 32'd0);
    check({tag, " done ready"}, 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    logic [31:0] old30;
    int d;
    logic [31:0] a;
    req_valid = '0; req_we = '0; req_unsigned = '0; rsp_ready = '0;
    req_size = '0; req_addr = '0; req_wdata = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check("reset rsp_rdata", rsp_rdata[i], 32'd0);
      check("reset rsp_err", 32'(rsp_err[i]), 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("post-reset req_ready0", 32'(req_ready[0]), 32'd1);
    check("post-reset req_ready1", 32'(req_ready[1]), 32'd1);

    // Give every word either DUT may read a known value.
    for (int w = 0; w < 16; w++) begin
      txn(0, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 0, "init0", got);
      txn(1, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 0, "init1", got);
    end

    txn(1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, "sw 0x10", got);
    txn(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, "lw 0x10", got);
    check("lw 0x10 const", got, 32'hDEADBEEF);
    txn(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01, 0, "sw 0x20", got);
    txn(1, 1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 0, "lb 0x23", got);
    check("lb 0x23 const", got, 32'hFFFFFF80);
    txn(1, 1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 0, "lbu 0x23", got);
    check("lbu 0x23 const", got, 32'h00000080);
    txn(1, 1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 0, "lb 0x21", got);
    check("lb 0x21 const", got, 32'h0000007F);
    txn(1, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 0, "lh 0x22", got);
    check("lh 0x22 const", got, 32'hFFFF80FF);
    txn(1, 1'b1, 2'd1, 1'b0, 32'h22, 32'h1234ABCD, 0, "sh 0x22", got);
    txn(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, "lw 0x20", got);
    check("lw 0x20 after sh", got, 32'hABCD7F01);

    txn(1, 1'b0, 2'd2, 1'b0, 32'h21, 32'h0, 0, "lw 0x21 err", got);
    txn(1, 1'b1, 2'd1, 1'b0, 32'h23, 32'hFFFFFFFF, 0, "sh 0x23 err", got);
    txn(1, 1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFFFFFF, 0, "size3 err", got);
    txn(1, 1'b1, 2'd2, 1'b0, 32'h400, 32'hFFFFFFFF, 0, "sw oob err", got);
    txn(1, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 0, "lw oob err", got);
    txn(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, "lw 0x20 unchanged", got);
    check("lw 0x20 unchanged const", got, 32'hABCD7F01);

    txn(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, "bp1", got);
    txn(0, 1'b1, 2'd2, 1'b0, 32'h3C, 32'hCAFEF00D, 0, "w0 sw", got);
    txn(0, 1'b0, 2'd1, 1'b1, 32'h3E, 32'h0, 5, "w0 lhu bp", got);
    check("w0 lhu const", got, 32'h0000CAFE);
    txn(0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0, "w0 oob", got);

    // Reset while a store sits in WAIT must drop the store.
    old30 = mdl_load(1, 2'd2, 1'b0, 32'h30);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'd2;
    req_unsigned[1] = 1'b0; req_addr[1] = 32'h30; req_wdata[1] = 32'h55;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    check("mid-op not yet valid", 32'(rsp_valid[1]), 32'd0);
    reset = 1'b0;
    #1;
    check("mid-op reset valid", 32'(rsp_valid[1]), 32'd0);
    check("mid-op reset ready", 32'(req_ready[1]), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("mid-op ready after reset", 32'(req_ready[1]), 32'd1);
    txn(1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 0, "lw 0x30 after abort", got);
    check("lw 0x30 old value", got, old30);

    for (int k = 0; k < 80; k++) begin
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 32'(depth_of[d] * 4) + $urandom_range(0, 255);
      else a = $urandom_range(0, 63);
      txn(d, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
          int'($urandom_range(0, 3)), "random", got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
